ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Parametrised PS/2 Set-2 scancode decoder sitting between `PS2_Controller` (`received_data`/`received_data_en`) and game control logic (hit/stand/deal and similar). Tracks `E0` extended and `F0` break prefixes with a stale-prefix timeout. Maintains a held/released state for `NUM_KEYS` configurable keys, emitting one-cycle press and release pulses that ignore typematic auto-repeat. Also reports every completed scancode for debug and LED display.

## Interface
- `NUM_KEYS`, 3: number of tracked keys, 1..16
- `KEY_CODES`, {8'h23, 8'h1B, 8'h33}: packed `NUM_KEYS*8` make codes; key i = bits [8i+7:8i] (default: key0 = H, key1 = S, key2 = D)
- `KEY_EXT`, 3'b000: packed `NUM_KEYS` bits; bit i = 1 means key i requires the `E0` prefix
- `TIMEOUT_CYCLES`, 50000: cycles a pending prefix may wait for its next byte (1 ms at 50 MHz); ≥2

- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `received_data`  in  8  byte from PS/2 controller
- `received_data_en`  in  1  one-cycle strobe, `received_data` valid
- `key_held`  out  NUM_KEYS  bit i = 1 while key i is down
- `key_pressed`  out  NUM_KEYS  one-cycle pulse on key i up→down
- `key_released`  out  NUM_KEYS  one-cycle pulse on key i down→up
- `code_valid`  out  1  one-cycle pulse, completed scancode in `last_*`
- `last_code`  out  8  final byte of the last completed scancode
- `last_ext`  out  1  last scancode carried `E0`
- `last_break`  out  1  last scancode carried `F0`
- `prefix_timeout`  out  1  one-cycle pulse when a pending prefix is discarded

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (after E0 F0).
- Strobed byte transitions:
  - `E0`: IDLE→EXT; from any other state →EXT (restart).
  - `F0`: IDLE→BRK, EXT→EXTBRK; in BRK/EXTBRK stay (duplicate ignored).
  - `FA`, `AA`, `EE`, `FE`, `00`, `FF`, `E1`: controller/protocol bytes; →IDLE, no scancode, no pulses.
  - Any other byte: completes a scancode with ext = (state ∈ {EXT, EXTBRK}) and brk = (state ∈ {BRK, EXTBRK}); →IDLE.
- On completion:
  - Register `last_code`/`last_ext`/`last_break` and pulse `code_valid`.
  - For every i with `KEY_CODES[i]` == byte and `KEY_EXT[i]` == ext:
    - make while not held: set held, pulse `key_pressed[i]`.
    - make while held (auto-repeat): no pulse.
    - break while held: clear held, pulse `key_released[i]`.
    - break while not held: no effect.
- Duplicate codes across entries are legal; all matching entries update identically.
- Timeout:
  - The counter clears on every strobe and counts while state ≠ IDLE.
  - On reaching `TIMEOUT_CYCLES-1`: →IDLE, pulse `prefix_timeout`, counter clears.
  - A strobe arriving on the same cycle as the timeout takes priority; no timeout pulse is issued.
- Counter width is `$clog2(TIMEOUT_CYCLES)`, saturating, with no wrap.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, all outputs 0 (`key_held` = 0, `last_code` = 8'h00).
- Reset mid-sequence discards any prefix and clears all held keys.
- Latency: strobe at cycle N → `code_valid`, `key_pressed`/`key_released`, `key_held`, and `last_*` updated at cycle N+1 (registered).
- All pulses are exactly one cycle wide.
- Back-to-back strobes on consecutive cycles are supported with full throughput.
- `received_data` is sampled only when `received_data_en` = 1; otherwise ignored.

## Test plan
- Make/break: strobe 33, then F0, 33 → `key_pressed[0]` pulse, `key_held[0]` = 1, then `key_released[0]` pulse, `key_held[0]` = 0; `last_break` = 1 on the second `code_valid`.
- Auto-repeat: strobe 1B ×4 → exactly one `key_pressed[1]` pulse, four `code_valid` pulses; F0, 1B → one `key_released[1]` pulse.
- Extended match: `KEY_EXT` = 3'b100, `KEY_CODES[2]` = 8'h75; strobe 75 → no key change; strobe E0, 75 → `key_pressed[2]`; E0, F0, 75 → `key_released[2]`, `last_ext` = 1, `last_break` = 1.
- Timeout: strobe F0, idle `TIMEOUT_CYCLES` cycles → `prefix_timeout` pulse; next strobe 33 is a make (`key_pressed[0]`), not a break.
- Protocol bytes and reset: strobe F0, FA, 33 → make of H; hold H and D, assert `reset` low mid-sequence after E0 → all outputs 0 immediately, first post-reset 23 produces `key_pressed[2]`.
- Back-to-back: strobes F0, 33 on consecutive cycles with H held → `key_released[0]` two cycles after the F0 strobe.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - scancode byte input and key/scancode status outputs of the PS/2 key decoder
interface ps2_key_decoder_if #(
   parameter int NUM_KEYS = 3
);
   logic [7:0]          received_data;
   logic                received_data_en;
   logic [NUM_KEYS-1:0] key_held;
   logic [NUM_KEYS-1:0] key_pressed;
   logic [NUM_KEYS-1:0] key_released;
   logic                code_valid;
   logic [7:0]          last_code;
   logic                last_ext;
   logic                last_break;
   logic                prefix_timeout;

   modport master (
      output received_data, received_data_en,
      input  key_held, key_pressed, key_released,
      input  code_valid, last_code, last_ext, last_break, prefix_timeout
   );

   modport slave (
      input  received_data, received_data_en,
      output key_held, key_pressed, key_released,
      output code_valid, last_code, last_ext, last_break, prefix_timeout
   );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scancode decoder with E0/F0 prefix tracking and held-key state
module ps2_key_decoder #(
   parameter int                    NUM_KEYS       = 3,
   parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h23, 8'h1B, 8'h33},
   parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
   parameter int                    TIMEOUT_CYCLES = 50000
) (
   input logic              CLOCK_50,
   input logic              reset,
   ps2_key_decoder_if.slave bus
);

   localparam int            CW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_next;

   logic                is_proto;
   logic                complete;
   logic                cur_ext;
   logic                cur_brk;
   logic                timeout_hit;

   logic [NUM_KEYS-1:0] held_q;
   logic [NUM_KEYS-1:0] held_next;
   logic [NUM_KEYS-1:0] press_q;
   logic [NUM_KEYS-1:0] press_next;
   logic [NUM_KEYS-1:0] release_q;
   logic [NUM_KEYS-1:0] release_next;
   logic                code_valid_q;
   logic [7:0]          last_code_q;
   logic                last_ext_q;
   logic                last_break_q;
   logic                timeout_q;

   // Classify controller/protocol bytes (ACK, BAT, echo, resend, overrun, pause prefix)
   always_comb begin
      is_proto = 1'b0;
      case (bus.received_data)
         8'hFA, 8'hAA, 8'hEE, 8'hFE,
         8'h00, 8'hFF, 8'hE1: is_proto = 1'b1;
         default:             is_proto = 1'b0;
      endcase
   end

   // Prefix FSM next state and stale-prefix timeout counter; a strobe always wins over a timeout
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      complete    = 1'b0;
      timeout_hit = 1'b0;
      cur_ext     = (state == ST_EXT) || (state == ST_EXTBRK);
      cur_brk     = (state == ST_BRK) || (state == ST_EXTBRK);

      if (bus.received_data_en) begin
         cnt_next = '0;
         if (bus.received_data == 8'hE0) begin
            state_next = ST_EXT;
         end else if (bus.received_data == 8'hF0) begin
            state_next = cur_ext ? ST_EXTBRK : ST_BRK;
         end else begin
            state_next = ST_IDLE;
            complete   = !is_proto;
         end
      end else if (state != ST_IDLE) begin
         if (cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            state_next  = ST_IDLE;
            cnt_next    = '0;
         end else begin
            cnt_next = cnt + CW'(1);
         end
      end else begin
         cnt_next = '0;
      end
   end

   // Per-key held/press/release update; auto-repeat makes and breaks of released keys are ignored
   always_comb begin
      held_next    = held_q;
      press_next   = '0;
      release_next = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (complete && (KEY_CODES[8*i +: 8] == bus.received_data) && (KEY_EXT[i] == cur_ext)) begin
            if (!cur_brk && !held_q[i]) begin
               held_next[i]  = 1'b1;
               press_next[i] = 1'b1;
            end else if (cur_brk && held_q[i]) begin
               held_next[i]    = 1'b0;
               release_next[i] = 1'b1;
            end
         end
      end
   end

   // Prefix state and timeout counter registers
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Registered key state, one-cycle pulses and last-scancode report
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         held_q       <= '0;
         press_q      <= '0;
         release_q    <= '0;
         code_valid_q <= 1'b0;
         last_code_q  <= 8'h00;
         last_ext_q   <= 1'b0;
         last_break_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         held_q       <= held_next;
         press_q      <= press_next;
         release_q    <= release_next;
         code_valid_q <= complete;
         timeout_q    <= timeout_hit;
         if (complete) begin
            last_code_q  <= bus.received_data;
            last_ext_q   <= cur_ext;
            last_break_q <= cur_brk;
         end
      end
   end

   assign bus.key_held       = held_q;
   assign bus.key_pressed    = press_q;
   assign bus.key_released   = release_q;
   assign bus.code_valid     = code_valid_q;
   assign bus.last_code      = last_code_q;
   assign bus.last_ext       = last_ext_q;
   assign bus.last_break     = last_break_q;
   assign bus.prefix_timeout = timeout_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized bench for ps2_key_decoder against a prefix/held-key reference model
module tb_ps2_key_decoder;

   localparam int T  = 16;
   localparam int NA = 3;
   localparam int NB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ps2_key_decoder_if #(.NUM_KEYS(NA)) bus_a ();
   ps2_key_decoder_if #(.NUM_KEYS(NB)) bus_b ();

   ps2_key_decoder #(
      .NUM_KEYS(NA), .KEY_CODES({8'h23, 8'h1B, 8'h33}), .KEY_EXT(3'b000), .TIMEOUT_CYCLES(T)
   ) dut_a (
      .CLOCK_50(clk), .reset(rst_n), .bus(bus_a.slave)
   );

   ps2_key_decoder #(
      .NUM_KEYS(NB), .KEY_CODES({8'h33, 8'h75, 8'h1B, 8'h33}), .KEY_EXT(4'b0100), .TIMEOUT_CYCLES(T)
   ) dut_b (
      .CLOCK_50(clk), .reset(rst_n), .bus(bus_b.slave)
   );

   int checks = 0;
   int errors = 0;

   // reference model: pending prefix flags, idle edges since last byte, per-key held flags
   int         nk[2];
   logic [7:0] mcode[2][4];
   logic       mext[2][4];
   logic [3:0] held[2];
   logic [3:0] press[2];
   logic [3:0] rel[2];
   logic       pend_ext, pend_brk;
   int         since;
   logic       exp_cv, exp_to, exp_ext, exp_brk;
   logic [7:0] exp_code;
   logic [7:0] protos[7];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      pend_ext = 1'b0;
      pend_brk = 1'b0;
      since    = 0;
      exp_cv   = 1'b0;
      exp_to   = 1'b0;
      exp_ext  = 1'b0;
      exp_brk  = 1'b0;
      exp_code = 8'h00;
      for (int d = 0; d < 2; d++) begin
         held[d]  = '0;
         press[d] = '0;
         rel[d]   = '0;
      end
   endtask

   function automatic bit is_protocol(input logic [7:0] b);
      for (int k = 0; k < 7; k++) if (protos[k] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input bit en, input logic [7:0] b);
      exp_cv = 1'b0;
      exp_to = 1'b0;
      for (int d = 0; d < 2; d++) begin
         press[d] = '0;
         rel[d]   = '0;
      end
      if (en) begin
         since = 0;
         if (b == 8'hE0) begin
            pend_ext = 1'b1;
            pend_brk = 1'b0;
         end else if (b == 8'hF0) begin
            pend_brk = 1'b1;
         end else if (is_protocol(b)) begin
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end else begin
            exp_cv   = 1'b1;
            exp_code = b;
            exp_ext  = pend_ext;
            exp_brk  = pend_brk;
            for (int d = 0; d < 2; d++) begin
               for (int i = 0; i < nk[d]; i++) begin
                  if (mcode[d][i] == b && mext[d][i] == pend_ext) begin
                     if (!pend_brk && !held[d][i]) begin
                        held[d][i]  = 1'b1;
                        press[d][i] = 1'b1;
                     end else if (pend_brk && held[d][i]) begin
                        held[d][i] = 1'b0;
                        rel[d][i]  = 1'b1;
                     end
                  end
               end
            end
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end
      end else begin
         since++;
         if ((pend_ext || pend_brk) && since == T) begin
            exp_to   = 1'b1;
            pend_ext = 1'b0;
            pend_brk = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      check_eq("a.code_valid", 32'(bus_a.code_valid), 32'(exp_cv));
      check_eq("a.last_code", 32'(bus_a.last_code), 32'(exp_code));
      check_eq("a.last_ext", 32'(bus_a.last_ext), 32'(exp_ext));
      check_eq("a.last_break", 32'(bus_a.last_break), 32'(exp_brk));
      check_eq("a.prefix_timeout", 32'(bus_a.prefix_timeout), 32'(exp_to));
      check_eq("a.key_held", 32'(bus_a.key_held), 32'(held[0][NA-1:0]));
      check_eq("a.key_pressed", 32'(bus_a.key_pressed), 32'(press[0][NA-1:0]));
      check_eq("a.key_released", 32'(bus_a.key_released), 32'(rel[0][NA-1:0]));
      check_eq("b.code_valid", 32'(bus_b.code_valid), 32'(exp_cv));
      check_eq("b.last_code", 32'(bus_b.last_code), 32'(exp_code));
      check_eq("b.prefix_timeout", 32'(bus_b.prefix_timeout), 32'(exp_to));
      check_eq("b.key_held", 32'(bus_b.key_held), 32'(held[1]));
      check_eq("b.key_pressed", 32'(bus_b.key_pressed), 32'(press[1]));
      check_eq("b.key_released", 32'(bus_b.key_released), 32'(rel[1]));
   endtask

   // one clock: drive inputs, let the edge happen, then compare 1 time unit later
   task automatic cycle(input bit en, input logic [7:0] b);
      bus_a.received_data_en = en;
      bus_a.received_data    = b;
      bus_b.received_data_en = en;
      bus_b.received_data    = b;
      @(posedge clk);
      #1;
      model_step(en, b);
      check_all();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      cycle(1'b1, b);
      for (int g = 0; g < gap; g++) cycle(1'b0, $urandom_range(0, 255));
   endtask

   task automatic do_reset();
      bus_a.received_data_en = 1'b0;
      bus_b.received_data_en = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      check_all();
   endtask

   function automatic logic [7:0] pick_byte();
      int r;
      r = $urandom_range(0, 99);
      if (r < 12) return 8'hE0;
      if (r < 27) return 8'hF0;
      if (r < 33) return protos[$urandom_range(0, 6)];
      if (r < 50) return 8'h33;
      if (r < 62) return 8'h1B;
      if (r < 72) return 8'h23;
      if (r < 82) return 8'h75;
      return 8'($urandom_range(0, 255));
   endfunction

   function automatic int pick_gap();
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) return 0;
      if (r < 90) return $urandom_range(1, 3);
      return $urandom_range(T - 2, T + 2);
   endfunction

   int cnt_a;
   int cnt_b;

   initial begin
      protos = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
      nk[0] = NA;
      nk[1] = NB;
      mcode[0] = '{8'h33, 8'h1B, 8'h23, 8'h00};
      mext[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
      mcode[1] = '{8'h33, 8'h1B, 8'h75, 8'h33};
      mext[1]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      bus_a.received_data_en = 1'b0;
      bus_a.received_data    = 8'h00;
      bus_b.received_data_en = 1'b0;
      bus_b.received_data    = 8'h00;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check_eq("reset.last_code", 32'(bus_a.last_code), 32'h0);
      #1;
      rst_n = 1'b1;

      // make / break of H
      send(8'h33, 1);
      send(8'hF0, 0);
      cycle(1'b1, 8'h33);
      check_eq("mb.released0", 32'(bus_a.key_released[0]), 32'h1);
      check_eq("mb.last_break", 32'(bus_a.last_break), 32'h1);
      send(8'h00, 2);

      // auto-repeat of S
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 8'h1B);
         cnt_a += int'(bus_a.key_pressed[1]);
         cnt_b += int'(bus_a.code_valid);
      end
      check_eq("rep.presses", 32'(cnt_a), 32'd1);
      check_eq("rep.code_valids", 32'(cnt_b), 32'd4);
      send(8'hF0, 0);
      send(8'h1B, 1);

      // extended key on dut_b key2
      send(8'h75, 1);
      send(8'hE0, 0);
      cycle(1'b1, 8'h75);
      check_eq("ext.pressed2", 32'(bus_b.key_pressed[2]), 32'h1);
      send(8'hE0, 0);
      send(8'hF0, 0);
      cycle(1'b1, 8'h75);
      check_eq("ext.released2", 32'(bus_b.key_released[2]), 32'h1);
      check_eq("ext.last_ext", 32'(bus_b.last_ext), 32'h1);

      // stale F0 prefix times out, next 33 is a make
      cnt_a = 0;
      cycle(1'b1, 8'hF0);
      for (int k = 0; k < T; k++) begin
         cycle(1'b0, 8'h00);
         cnt_a += int'(bus_a.prefix_timeout);
      end
      check_eq("to.pulses", 32'(cnt_a), 32'd1);
      cycle(1'b1, 8'h33);
      check_eq("to.make0", 32'(bus_a.key_pressed[0]), 32'h1);

      // protocol byte drops the F0 prefix, then reset with H and D held after E0
      send(8'hF0, 0);
      send(8'h33, 0);
      send(8'hF0, 0);
      send(8'hFA, 0);
      send(8'h33, 0);
      send(8'h23, 0);
      send(8'hE0, 0);
      do_reset();
      cycle(1'b1, 8'h23);
      check_eq("rst.pressed2", 32'(bus_a.key_pressed[2]), 32'h1);

      // back-to-back release of held H
      send(8'h33, 0);
      send(8'hF0, 0);
      send(8'h33, 0);

      // randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         send(pick_byte(), pick_gap());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
